// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC sample-averaging datapath: sample width,
// DRP channel addresses and the averager state encoding.
package xadc_pkg;

  localparam int XADC_SAMPLE_W = 12;

  localparam logic [4:0] CH_TEMP  = 5'h00;
  localparam logic [4:0] CH_VAUX6 = 5'h16;

  typedef enum logic {
    IDLE,
    ACCUM
  } avg_state_e;

endpackage

// File: rtl/xadc_sample_avg_if.sv
// DRP read-result stream from the XADC wizard plus the averaged-result
// valid/ready stream towards the display logic.
interface xadc_sample_avg_if;
  import xadc_pkg::*;

  logic                     drdy_in;
  logic [15:0]              do_in;
  logic [4:0]               channel_in;
  logic [XADC_SAMPLE_W-1:0] avg_data;
  logic                     avg_valid;
  logic                     avg_ready;

  // The averager: consumes DRP results, produces averages.
  modport slave (
    input  drdy_in,
    input  do_in,
    input  channel_in,
    input  avg_ready,
    output avg_data,
    output avg_valid
  );

  // The environment: XADC wizard on one side, display consumer on the other.
  modport master (
    output drdy_in,
    output do_in,
    output channel_in,
    output avg_ready,
    input  avg_data,
    input  avg_valid
  );

endinterface

// File: rtl/xadc_minmax_track.sv
// Running minimum/maximum of accepted raw XADC samples with a synchronous
// clear; a clear coinciding with a sample seeds both extremes with it.
module xadc_minmax_track
  import xadc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_vld,
  input  logic [XADC_SAMPLE_W-1:0] sample,
  input  logic                     clr,
  output logic [XADC_SAMPLE_W-1:0] min_out,
  output logic [XADC_SAMPLE_W-1:0] max_out
);

  logic [XADC_SAMPLE_W-1:0] min_p1;
  logic [XADC_SAMPLE_W-1:0] max_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_p1 <= '1;
      max_p1 <= '0;
    end else if (clr) begin
      min_p1 <= sample_vld ? sample : '1;
      max_p1 <= sample_vld ? sample : '0;
    end else if (sample_vld) begin
      if (sample < min_p1) min_p1 <= sample;
      if (sample > max_p1) max_p1 <= sample;
    end
  end

  assign min_out = min_p1;
  assign max_out = max_p1;

endmodule

// File: rtl/xadc_sample_avg.sv
// Channel-qualified box-car average of 2^LOG2_N XADC DRP results with a
// valid/ready output. Define XADC_AVG_MINMAX_EN to add min/max tracking.
module xadc_sample_avg
  import xadc_pkg::*;
#(
  parameter logic [4:0] CHANNEL = CH_VAUX6,
  parameter int         LOG2_N  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  xadc_sample_avg_if.slave         dbus,
  output logic [XADC_SAMPLE_W-1:0] last_sample,
  output logic [7:0]               overrun_cnt
`ifdef XADC_AVG_MINMAX_EN
  ,
  input  logic                     minmax_clr,
  output logic [XADC_SAMPLE_W-1:0] min_out,
  output logic [XADC_SAMPLE_W-1:0] max_out
`endif
);

  // Wide enough to hold N full-scale samples, so the sum never wraps.
  localparam int ACC_W = XADC_SAMPLE_W + LOG2_N;

  function automatic logic [XADC_SAMPLE_W-1:0] trunc_avg(input logic [ACC_W-1:0] s);
    return XADC_SAMPLE_W'(s >> LOG2_N);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  avg_state_e               state_p1;
  logic [ACC_W-1:0]         acc_p1;
  logic [LOG2_N-1:0]        cnt_p1;
  logic [XADC_SAMPLE_W-1:0] avg_data_p1;
  logic                     vld_p1;
  logic [XADC_SAMPLE_W-1:0] last_sample_p1;
  logic [7:0]               overrun_p1;

  logic [XADC_SAMPLE_W-1:0] sample_p0;
  logic                     acc_ok_p0;
  logic                     take_p0;
  logic                     final_p0;
  logic [ACC_W-1:0]         sum_p0;
  logic                     unused_do_lsbs;

  // Stage 0: qualify the DRP result and form the running sum.
  assign sample_p0      = dbus.do_in[15:4];
  assign unused_do_lsbs = &{1'b0, dbus.do_in[3:0]};
  assign acc_ok_p0      = en & dbus.drdy_in & (dbus.channel_in == CHANNEL);
  assign take_p0        = acc_ok_p0 & (state_p1 == ACCUM);
  assign final_p0       = (cnt_p1 == {LOG2_N{1'b1}});
  assign sum_p0         = acc_p1 + ACC_W'(sample_p0);

  // Stage 1: accumulator, averager FSM and output handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1       <= IDLE;
      acc_p1         <= '0;
      cnt_p1         <= '0;
      avg_data_p1    <= '0;
      vld_p1         <= 1'b0;
      last_sample_p1 <= '0;
      overrun_p1     <= '0;
    end else begin
      // A completion on this edge overrides the transfer-driven drop below.
      if (vld_p1 && dbus.avg_ready) vld_p1 <= 1'b0;

      case (state_p1)
        IDLE: begin
          acc_p1 <= '0;
          cnt_p1 <= '0;
          if (en) state_p1 <= ACCUM;
        end
        ACCUM: begin
          if (!en) begin
            state_p1 <= IDLE;
            acc_p1   <= '0;
            cnt_p1   <= '0;
          end else if (take_p0) begin
            last_sample_p1 <= sample_p0;
            if (final_p0) begin
              avg_data_p1 <= trunc_avg(sum_p0);
              vld_p1      <= 1'b1;
              if (vld_p1 && !dbus.avg_ready) overrun_p1 <= sat_inc8(overrun_p1);
              acc_p1      <= '0;
              cnt_p1      <= '0;
            end else begin
              acc_p1 <= sum_p0;
              cnt_p1 <= cnt_p1 + LOG2_N'(1);
            end
          end
        end
      endcase
    end
  end

  assign dbus.avg_data  = avg_data_p1;
  assign dbus.avg_valid = vld_p1;
  assign last_sample    = last_sample_p1;
  assign overrun_cnt    = overrun_p1;

`ifdef XADC_AVG_MINMAX_EN
  xadc_minmax_track u_minmax (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_vld (take_p0),
    .sample     (sample_p0),
    .clr        (minmax_clr),
    .min_out    (min_out),
    .max_out    (max_out)
  );
`endif

endmodule

// File: tb/tb_xadc_sample_avg.sv
// Directed bench for xadc_sample_avg (LOG2_N=4, CHANNEL=VAUX6); the min/max
// scenario is included when XADC_AVG_MINMAX_EN is defined.
module tb_xadc_sample_avg;
  import xadc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [11:0] last_sample;
  logic [7:0]  overrun_cnt;
`ifdef XADC_AVG_MINMAX_EN
  logic        minmax_clr;
  logic [11:0] min_out;
  logic [11:0] max_out;
`endif

  int total = 0;
  int bad   = 0;

  xadc_sample_avg_if dbus ();

  xadc_sample_avg #(
    .CHANNEL (5'h16),
    .LOG2_N  (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .dbus        (dbus),
    .last_sample (last_sample),
    .overrun_cnt (overrun_cnt)
`ifdef XADC_AVG_MINMAX_EN
    ,
    .minmax_clr  (minmax_clr),
    .min_out     (min_out),
    .max_out     (max_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One drdy cycle; low nibble is junk that the DUT must discard.
  task automatic pulse(input logic [11:0] s, input logic [4:0] ch);
    dbus.drdy_in    = 1'b1;
    dbus.do_in      = {s, 4'hA};
    dbus.channel_in = ch;
    step();
    dbus.drdy_in    = 1'b0;
    dbus.do_in      = 16'h0000;
    dbus.channel_in = 5'h00;
  endtask

  task automatic burst(input logic [11:0] s, input int n);
    for (int i = 0; i < n; i++) pulse(s, 5'h16);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en              = 1'($urandom);
      dbus.drdy_in    = 1'($urandom);
      dbus.do_in      = 16'($urandom);
      dbus.channel_in = 5'h16;
      dbus.avg_ready  = 1'($urandom);
      step();
    end
    total++;
    if (dbus.avg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", dbus.avg_valid); end
    total++;
    if (dbus.avg_data !== 12'h000) begin bad++; $display("FAIL reset_data got=%0h want=0", dbus.avg_data); end
    total++;
    if (last_sample !== 12'h000) begin bad++; $display("FAIL reset_last got=%0h want=0", last_sample); end
    total++;
    if (overrun_cnt !== 8'h00) begin bad++; $display("FAIL reset_overrun got=%0h want=0", overrun_cnt); end
    en             = 1'b0;
    dbus.drdy_in   = 1'b0;
    dbus.do_in     = 16'h0000;
    dbus.avg_ready = 1'b0;
    reset_n        = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (dbus.avg_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%0h want=0", dbus.avg_valid); end
  endtask

  task automatic test_average();
    dbus.avg_ready = 1'b1;
    en = 1'b1;
    step();
    burst(12'h800, 15);
    total++;
    if (dbus.avg_valid !== 1'b0) begin bad++; $display("FAIL avg_early_valid got=%0h want=0", dbus.avg_valid); end
    pulse(12'h800, 5'h16);
    total++;
    if (dbus.avg_valid !== 1'b1) begin bad++; $display("FAIL avg_valid got=%0h want=1", dbus.avg_valid); end
    total++;
    if (dbus.avg_data !== 12'h800) begin bad++; $display("FAIL avg_data got=%0h want=800", dbus.avg_data); end
    total++;
    if (last_sample !== 12'h800) begin bad++; $display("FAIL avg_last got=%0h want=800", last_sample); end
    step();
    total++;
    if (dbus.avg_valid !== 1'b0) begin bad++; $display("FAIL avg_drop got=%0h want=0", dbus.avg_valid); end
  endtask

  task automatic test_truncation();
    dbus.avg_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pulse(12'(i), 5'h16);
      if (i < 15) pulse(12'hFFF, 5'h00);
      if (i == 7) begin
        total++;
        if (last_sample !== 12'h007) begin bad++; $display("FAIL filter_last got=%0h want=7", last_sample); end
      end
    end
    total++;
    if (dbus.avg_valid !== 1'b1) begin bad++; $display("FAIL trunc_valid got=%0h want=1", dbus.avg_valid); end
    total++;
    if (dbus.avg_data !== 12'h007) begin bad++; $display("FAIL trunc_data got=%0h want=7", dbus.avg_data); end
    step();
  endtask

  task automatic test_overrun();
    dbus.avg_ready = 1'b0;
    burst(12'h100, 16);
    total++;
    if (dbus.avg_data !== 12'h100 || overrun_cnt !== 8'd0) begin
      bad++; $display("FAIL ovr_first got data=%0h cnt=%0d want data=100 cnt=0", dbus.avg_data, overrun_cnt);
    end
    burst(12'h200, 8);
    total++;
    if (dbus.avg_data !== 12'h100 || dbus.avg_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_hold got data=%0h valid=%0h want data=100 valid=1", dbus.avg_data, dbus.avg_valid);
    end
    burst(12'h200, 8);
    total++;
    if (dbus.avg_data !== 12'h200 || overrun_cnt !== 8'd1) begin
      bad++; $display("FAIL ovr_second got data=%0h cnt=%0d want data=200 cnt=1", dbus.avg_data, overrun_cnt);
    end
    burst(12'h300, 16);
    total++;
    if (dbus.avg_data !== 12'h300 || overrun_cnt !== 8'd2 || dbus.avg_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_third got data=%0h cnt=%0d valid=%0h want data=300 cnt=2 valid=1",
                      dbus.avg_data, overrun_cnt, dbus.avg_valid);
    end
    dbus.avg_ready = 1'b1;
    step();
    total++;
    if (dbus.avg_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%0h want=0", dbus.avg_valid); end
  endtask

  task automatic test_back_to_back();
    dbus.avg_ready = 1'b0;
    burst(12'h040, 16);
    total++;
    if (dbus.avg_data !== 12'h040 || dbus.avg_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_first got data=%0h valid=%0h want data=40 valid=1", dbus.avg_data, dbus.avg_valid);
    end
    burst(12'h0C0, 15);
    dbus.avg_ready = 1'b1;
    pulse(12'h0C0, 5'h16);
    total++;
    if (dbus.avg_data !== 12'h0C0 || dbus.avg_valid !== 1'b1 || overrun_cnt !== 8'd2) begin
      bad++; $display("FAIL b2b_same_edge got data=%0h valid=%0h cnt=%0d want data=c0 valid=1 cnt=2",
                      dbus.avg_data, dbus.avg_valid, overrun_cnt);
    end
    step();
    total++;
    if (dbus.avg_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%0h want=0", dbus.avg_valid); end
  endtask

  task automatic test_en_abort();
    dbus.avg_ready = 1'b1;
    burst(12'hFFF, 10);
    en = 1'b0;
    step();
    total++;
    if (last_sample !== 12'hFFF || dbus.avg_data !== 12'h0C0) begin
      bad++; $display("FAIL abort_hold got last=%0h data=%0h want last=fff data=c0", last_sample, dbus.avg_data);
    end
    en = 1'b1;
    step();
    burst(12'h100, 6);
    total++;
    if (dbus.avg_valid !== 1'b0) begin bad++; $display("FAIL abort_partial got=%0h want=0", dbus.avg_valid); end
    burst(12'h100, 10);
    total++;
    if (dbus.avg_data !== 12'h100 || dbus.avg_valid !== 1'b1) begin
      bad++; $display("FAIL abort_data got data=%0h valid=%0h want data=100 valid=1", dbus.avg_data, dbus.avg_valid);
    end
    step();
  endtask

`ifdef XADC_AVG_MINMAX_EN
  task automatic test_minmax();
    minmax_clr = 1'b1;
    step();
    minmax_clr = 1'b0;
    total++;
    if (min_out !== 12'hFFF || max_out !== 12'h000) begin
      bad++; $display("FAIL mm_clear got min=%0h max=%0h want min=fff max=0", min_out, max_out);
    end
    pulse(12'h300, 5'h16);
    pulse(12'h001, 5'h00);
    pulse(12'h050, 5'h16);
    pulse(12'hA00, 5'h16);
    total++;
    if (min_out !== 12'h050 || max_out !== 12'hA00) begin
      bad++; $display("FAIL mm_track got min=%0h max=%0h want min=50 max=a00", min_out, max_out);
    end
    minmax_clr = 1'b1;
    step();
    minmax_clr = 1'b0;
    total++;
    if (min_out !== 12'hFFF || max_out !== 12'h000) begin
      bad++; $display("FAIL mm_reclear got min=%0h max=%0h want min=fff max=0", min_out, max_out);
    end
    minmax_clr = 1'b1;
    pulse(12'h444, 5'h16);
    minmax_clr = 1'b0;
    total++;
    if (min_out !== 12'h444 || max_out !== 12'h444) begin
      bad++; $display("FAIL mm_clr_sample got min=%0h max=%0h want 444/444", min_out, max_out);
    end
  endtask
`endif

  task automatic test_reset_mid();
    dbus.avg_ready = 1'b1;
    burst(12'hFFF, 5);
    reset_n = 1'b0;
    #2;
    total++;
    if (last_sample !== 12'h000 || overrun_cnt !== 8'd0 || dbus.avg_data !== 12'h000) begin
      bad++; $display("FAIL async_reset got last=%0h cnt=%0d data=%0h want 0/0/0", last_sample, overrun_cnt, dbus.avg_data);
    end
    step();
    reset_n = 1'b1;
    step();
    burst(12'h200, 15);
    total++;
    if (dbus.avg_valid !== 1'b0) begin bad++; $display("FAIL rmid_partial got=%0h want=0", dbus.avg_valid); end
    pulse(12'h200, 5'h16);
    total++;
    if (dbus.avg_data !== 12'h200 || dbus.avg_valid !== 1'b1) begin
      bad++; $display("FAIL rmid_data got data=%0h valid=%0h want data=200 valid=1", dbus.avg_data, dbus.avg_valid);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    en              = 1'b0;
    dbus.drdy_in    = 1'b0;
    dbus.do_in      = 16'h0000;
    dbus.channel_in = 5'h00;
    dbus.avg_ready  = 1'b0;
`ifdef XADC_AVG_MINMAX_EN
    minmax_clr      = 1'b0;
`endif
    test_reset();
    test_average();
    test_truncation();
    test_overrun();
    test_back_to_back();
    test_en_abort();
`ifdef XADC_AVG_MINMAX_EN
    test_minmax();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
